// File: rtl/operand_entry_if.sv
// Keypad-to-operand bus: decoded key strobes in, frozen BCD operand and status out.
interface operand_entry_if #(
   parameter int NUM_DIGITS = 3
);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   logic                        key_valid;
   logic [3:0]                  key_code;
   logic                        start_new;
   logic [NUM_DIGITS-1:0][3:0]  bcds;
   logic                        negative;
   logic [CW-1:0]               digit_count;
   logic                        out_of_range;
   logic                        entry_done;
   logic                        locked;
   logic                        key_reject;

   modport master (
      output key_valid, key_code, start_new,
      input  bcds, negative, digit_count, out_of_range, entry_done, locked, key_reject
   );

   modport slave (
      input  key_valid, key_code, start_new,
      output bcds, negative, digit_count, out_of_range, entry_done, locked, key_reject
   );
endinterface

// File: rtl/operand_entry.sv
// Keypad operand entry: accumulates BCD digits and a sign, freezes on enter until
// the controller releases it with start_new or the user presses clear.
module operand_entry #(
   parameter int          NUM_DIGITS = 3,
   parameter int unsigned MAX_POS    = 511,
   parameter int unsigned MAX_NEG    = 512
) (
   input  logic           clk,
   input  logic           rst,
   operand_entry_if.slave bus
);
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam int MW = $clog2(10 ** NUM_DIGITS);

   localparam logic [3:0] KEY_SIGN  = 4'd10;
   localparam logic [3:0] KEY_BKSP  = 4'd11;
   localparam logic [3:0] KEY_CLEAR = 4'd12;
   localparam logic [3:0] KEY_ENTER = 4'd13;

   typedef enum logic [1:0] {EMPTY, ENTERING, FULL, LOCKED} state_t;

   state_t                     state_reg, state_next;
   logic [NUM_DIGITS-1:0][3:0] bcds_reg, bcds_next, bcds_up, bcds_dn;
   logic                       negative_reg, negative_next;
   logic [CW-1:0]              count_reg, count_next;
   logic                       oor_reg, oor_next;
   logic                       done_reg, done_next;
   logic                       reject_reg, reject_next;
   logic                       clear_op, enter_go;
   logic [MW-1:0]              mag_next;

   // Pre-shifted digit vectors for digit insert (up) and backspace (down).
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shift
         if (gi == 0) begin : g_lo
            assign bcds_up[gi] = bus.key_code;
         end else begin : g_up
            assign bcds_up[gi] = bcds_reg[gi-1];
         end
         if (gi == NUM_DIGITS - 1) begin : g_hi
            assign bcds_dn[gi] = 4'd0;
         end else begin : g_dn
            assign bcds_dn[gi] = bcds_reg[gi+1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= EMPTY;
         bcds_reg     <= '0;
         negative_reg <= 1'b0;
         count_reg    <= '0;
         oor_reg      <= 1'b0;
         done_reg     <= 1'b0;
         reject_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bcds_reg     <= bcds_next;
         negative_reg <= negative_next;
         count_reg    <= count_next;
         oor_reg      <= oor_next;
         done_reg     <= done_next;
         reject_reg   <= reject_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clear_op) begin
         state_next = EMPTY;
      end else if (state_reg == LOCKED || enter_go) begin
         state_next = LOCKED;
      end else if (count_next == '0) begin
         state_next = EMPTY;
      end else if (count_next == CW'(NUM_DIGITS)) begin
         state_next = FULL;
      end else begin
         state_next = ENTERING;
      end
   end

   // start_new outranks any simultaneous key, which is dropped silently.
   always_comb begin
      bcds_next     = bcds_reg;
      negative_next = negative_reg;
      count_next    = count_reg;
      done_next     = 1'b0;
      reject_next   = 1'b0;
      clear_op      = 1'b0;
      enter_go      = 1'b0;
      if (bus.start_new) begin
         clear_op = 1'b1;
      end else if (bus.key_valid) begin
         if (bus.key_code <= 4'd9) begin
            if (state_reg == LOCKED || count_reg == CW'(NUM_DIGITS)) begin
               reject_next = 1'b1;
            end else if (!(count_reg == '0 && bus.key_code == 4'd0)) begin
               bcds_next  = bcds_up;
               count_next = count_reg + CW'(1);
            end
         end else if (bus.key_code == KEY_SIGN) begin
            if (state_reg == LOCKED) reject_next = 1'b1;
            else negative_next = ~negative_reg;
         end else if (bus.key_code == KEY_BKSP) begin
            if (state_reg == LOCKED || count_reg == '0) begin
               reject_next = 1'b1;
            end else begin
               bcds_next  = bcds_dn;
               count_next = count_reg - CW'(1);
            end
         end else if (bus.key_code == KEY_CLEAR) begin
            clear_op = 1'b1;
         end else if (bus.key_code == KEY_ENTER) begin
            if (state_reg == LOCKED) begin
               reject_next = 1'b1;
            end else begin
               enter_go  = 1'b1;
               done_next = 1'b1;
            end
         end
      end
      if (clear_op) begin
         bcds_next     = '0;
         negative_next = 1'b0;
         count_next    = '0;
      end
   end

   always_comb begin
      mag_next = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         mag_next = MW'(mag_next * MW'(10)) + MW'(bcds_next[i]);
      end
      oor_next = negative_next ? (32'(mag_next) > MAX_NEG) : (32'(mag_next) > MAX_POS);
   end

   assign bus.bcds         = bcds_reg;
   assign bus.negative     = negative_reg;
   assign bus.digit_count  = count_reg;
   assign bus.out_of_range = oor_reg;
   assign bus.entry_done   = done_reg;
   assign bus.locked       = (state_reg == LOCKED);
   assign bus.key_reject   = reject_reg;
endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed vector table, async reset sequence, and random
// keypresses checked against a queue-based model of the operand.
module tb_operand_entry;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_entry_if #(.NUM_DIGITS(ND)) bus ();

   operand_entry #(.NUM_DIGITS(ND), .MAX_POS(511), .MAX_NEG(512)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_step = 0;

   // Model: digits entered, most significant first.
   int   m_q[$];
   logic m_neg, m_lock, m_done, m_rej;

   typedef struct {
      logic       kv;
      logic [3:0] code;
      logic       sn;
      logic [11:0] b;
      logic       n;
      logic [1:0] c;
      logic       o, d, l, r;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic kv, logic [3:0] code, logic sn, logic [11:0] b,
                               logic n, logic [1:0] c, logic o, logic d, logic l, logic r);
      vec_t v;
      v.kv = kv; v.code = code; v.sn = sn; v.b = b; v.n = n; v.c = c;
      v.o = o; v.d = d; v.l = l; v.r = r;
      return v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_neg = 0; m_lock = 0; m_done = 0; m_rej = 0;
   endtask

   task automatic model_step(input logic kv, input logic [3:0] code, input logic sn);
      m_done = 0; m_rej = 0;
      if (sn) begin
         m_q.delete(); m_neg = 0; m_lock = 0;
      end else if (kv) begin
         if (code <= 9) begin
            if (m_lock || m_q.size() == ND) m_rej = 1;
            else if (!(m_q.size() == 0 && code == 0)) m_q.push_back(int'(code));
         end else if (code == 10) begin
            if (m_lock) m_rej = 1; else m_neg = !m_neg;
         end else if (code == 11) begin
            if (m_lock || m_q.size() == 0) m_rej = 1; else void'(m_q.pop_back());
         end else if (code == 12) begin
            m_q.delete(); m_neg = 0; m_lock = 0;
         end else if (code == 13) begin
            if (m_lock) m_rej = 1; else begin m_lock = 1; m_done = 1; end
         end
      end
   endtask

   function automatic logic [11:0] model_bcds();
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < m_q.size(); i++) r[4*i +: 4] = 4'(m_q[m_q.size()-1-i]);
      return r;
   endfunction

   function automatic logic model_oor();
      int mag;
      mag = 0;
      foreach (m_q[i]) mag = mag * 10 + m_q[i];
      return m_neg ? (mag > 512) : (mag > 511);
   endfunction

   task automatic cmp(input string tag, input string fld, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s.%s got=%0h exp=%0h", tag, fld, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [11:0] eb, input logic en,
                            input logic [1:0] ec, input logic eo, input logic ed,
                            input logic el, input logic er);
      cmp(tag, "bcds", 32'(bus.bcds), 32'(eb));
      cmp(tag, "negative", 32'(bus.negative), 32'(en));
      cmp(tag, "digit_count", 32'(bus.digit_count), 32'(ec));
      cmp(tag, "out_of_range", 32'(bus.out_of_range), 32'(eo));
      cmp(tag, "entry_done", 32'(bus.entry_done), 32'(ed));
      cmp(tag, "locked", 32'(bus.locked), 32'(el));
      cmp(tag, "key_reject", 32'(bus.key_reject), 32'(er));
   endtask

   task automatic step(input logic kv, input logic [3:0] code, input logic sn);
      @(negedge clk);
      bus.key_valid = kv; bus.key_code = code; bus.start_new = sn;
      @(posedge clk);
      model_step(kv, code, sn);
      #1;
      bus.key_valid = 1'b0; bus.start_new = 1'b0;
      n_step++;
      $display("step %0d kv=%0d code=%0d sn=%0d -> bcds=%03h neg=%0d cnt=%0d oor=%0d done=%0d lock=%0d rej=%0d",
               n_step, kv, code, sn, bus.bcds, bus.negative, bus.digit_count,
               bus.out_of_range, bus.entry_done, bus.locked, bus.key_reject);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.start_new = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all("reset", 12'h000, 0, 2'd0, 0, 0, 0, 0);

      // kv code sn | bcds neg cnt oor done lock rej
      tbl.push_back(mk(1, 1,  0, 12'h001, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2,  0, 12'h012, 0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3,  0, 12'h123, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4,  0, 12'h123, 0, 3, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,  0, 12'h123, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12, 0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0,  0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0,  0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 7,  0, 12'h007, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 11, 0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 11, 0, 12'h000, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 5,  0, 12'h005, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1,  0, 12'h051, 0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2,  0, 12'h512, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(1, 10, 0, 12'h512, 1, 3, 0, 0, 0, 0));
      tbl.push_back(mk(1, 10, 0, 12'h512, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(1, 11, 0, 12'h051, 0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12, 0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4,  0, 12'h004, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2,  0, 12'h042, 0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 13, 0, 12'h042, 0, 2, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0,  0, 12'h042, 0, 2, 0, 0, 1, 0));
      tbl.push_back(mk(1, 9,  0, 12'h042, 0, 2, 0, 0, 1, 1));
      tbl.push_back(mk(1, 10, 0, 12'h042, 0, 2, 0, 0, 1, 1));
      tbl.push_back(mk(1, 13, 0, 12'h042, 0, 2, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0,  1, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4,  0, 12'h004, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8,  1, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3,  0, 12'h003, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 14, 0, 12'h003, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 15, 0, 12'h003, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 12, 0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 13, 0, 12'h000, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 12, 0, 12'h000, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 10, 0, 12'h000, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 9,  0, 12'h009, 1, 1, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].kv, tbl[i].code, tbl[i].sn);
         check_all($sformatf("vec%0d", i), tbl[i].b, tbl[i].n, tbl[i].c,
                   tbl[i].o, tbl[i].d, tbl[i].l, tbl[i].r);
      end

      // Asynchronous reset while FULL must clear outputs before the next edge.
      do_reset();
      step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
      check_all("full", 12'h123, 0, 2'd3, 0, 0, 0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_all("async_rst", 12'h000, 0, 2'd0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      model_reset();
      step(1, 5, 0);
      check_all("after_rst", 12'h005, 0, 2'd1, 0, 0, 0, 0);

      // Random keypresses against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic       kv, sn;
         logic [3:0] code;
         int         sel;
         sel  = int'($urandom_range(0, 99));
         kv   = (sel < 85);
         sn   = ($urandom_range(0, 19) == 0);
         if (sel < 55)      code = 4'($urandom_range(0, 9));
         else if (sel < 65) code = 4'd10;
         else if (sel < 74) code = 4'd11;
         else if (sel < 78) code = 4'd12;
         else if (sel < 83) code = 4'd13;
         else               code = 4'($urandom_range(14, 15));
         step(kv, code, sn);
         check_all($sformatf("rnd%0d", i), model_bcds(), m_neg, 2'(m_q.size()),
                   model_oor(), m_done, m_lock, m_rej);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
